// File: rtl/aes_sbox_share_ctrl.sv
// Shares one external byte-wide AES S-box between the round datapath (16 bytes)
// and the key schedule (4 bytes). Optional round anti-starvation: AES_SBOX_STARVE_GUARD_EN.
module aes_sbox_share_ctrl #(
    parameter int SBOX_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rnd_req,
    input  logic         rnd_inv,
    input  logic [127:0] rnd_data,
    output logic         rnd_ack,
    output logic         rnd_done,
    output logic [127:0] rnd_result,
    input  logic         key_req,
    input  logic [31:0]  key_word,
    output logic         key_ack,
    output logic         key_done,
    output logic [31:0]  key_result,
    output logic [7:0]   sbox_in,
    output logic         sbox_inv,
    input  logic [7:0]   sbox_out,
    output logic         busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]   state_q;
    logic         job_key_q;
    logic         job_inv_q;
    logic [127:0] job_data_q;
    logic [127:0] lanes_q;
    logic [127:0] lanes_nxt;
    logic [3:0]   issue_cnt_q;
    logic [3:0]   cap_cnt_q;
    logic [3:0]   last_idx;
    logic         issuing;
    logic         cap_vld;
    logic         cap_last;
    logic         arb_ok;
    logic         grant_key;
    logic         grant_rnd;

    assign last_idx = job_key_q ? 4'd3 : 4'd15;
    assign issuing  = (state_q == ISSUE);
    assign cap_last = cap_vld && (cap_cnt_q == last_idx);
    // DONE arbitrates too, so back-to-back jobs lose no extra cycle
    assign arb_ok   = (state_q == IDLE) || (state_q == DONE);

`ifdef AES_SBOX_STARVE_GUARD_EN
    logic [1:0] starve_q;

    assign grant_rnd = arb_ok && rnd_req && (!key_req || (starve_q == 2'd2));
    assign grant_key = arb_ok && key_req && !grant_rnd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= 2'd0;
        end else if (grant_rnd) begin
            starve_q <= 2'd0;
        end else if (grant_key) begin
            if (!rnd_req) begin
                starve_q <= 2'd0;
            end else if (starve_q != 2'd3) begin
                starve_q <= starve_q + 2'd1;
            end
        end
    end
`else
    assign grant_key = arb_ok && key_req;
    assign grant_rnd = arb_ok && rnd_req && !key_req;
`endif

    // Capture valid trails the issue valid by the S-box latency
    generate
        if (SBOX_LAT == 0) begin : g_comb
            assign cap_vld = issuing;
        end else begin : g_pipe
            logic [SBOX_LAT-1:0] vld_p;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p <= '0;
                end else begin
                    vld_p[0] <= issuing;
                    for (int i = 1; i < SBOX_LAT; i++) begin
                        vld_p[i] <= vld_p[i-1];
                    end
                end
            end

            assign cap_vld = vld_p[SBOX_LAT-1];
        end
    endgenerate

    always_comb begin
        lanes_nxt = lanes_q;
        if (cap_vld) begin
            lanes_nxt[{cap_cnt_q, 3'b000} +: 8] = sbox_out;
        end
    end

    assign sbox_in  = issuing ? job_data_q[{issue_cnt_q, 3'b000} +: 8] : 8'h00;
    assign sbox_inv = ((state_q == ISSUE) || (state_q == DRAIN)) && job_inv_q;
    assign busy     = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            job_key_q   <= 1'b0;
            job_inv_q   <= 1'b0;
            issue_cnt_q <= 4'd0;
            cap_cnt_q   <= 4'd0;
            rnd_ack     <= 1'b0;
            key_ack     <= 1'b0;
            rnd_done    <= 1'b0;
            key_done    <= 1'b0;
            rnd_result  <= '0;
            key_result  <= '0;
        end else begin
            rnd_ack  <= 1'b0;
            key_ack  <= 1'b0;
            rnd_done <= 1'b0;
            key_done <= 1'b0;

            case (state_q)
                IDLE, DONE: begin
                    issue_cnt_q <= 4'd0;
                    cap_cnt_q   <= 4'd0;
                    if (grant_key) begin
                        state_q   <= ISSUE;
                        job_key_q <= 1'b1;
                        job_inv_q <= 1'b0;
                        key_ack   <= 1'b1;
                    end else if (grant_rnd) begin
                        state_q   <= ISSUE;
                        job_key_q <= 1'b0;
                        job_inv_q <= rnd_inv;
                        rnd_ack   <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ISSUE: begin
                    issue_cnt_q <= issue_cnt_q + 4'd1;
                    if (cap_last) begin
                        state_q <= DONE;
                    end else if (issue_cnt_q == last_idx) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (cap_last) begin
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (cap_vld) begin
                cap_cnt_q <= cap_cnt_q + 4'd1;
            end

            if (cap_last) begin
                if (job_key_q) begin
                    key_done   <= 1'b1;
                    key_result <= lanes_nxt[31:0];
                end else begin
                    rnd_done   <= 1'b1;
                    rnd_result <= lanes_nxt;
                end
            end
        end
    end

    // Job payload and lane buffer carry no reset; outputs are gated by state
    always_ff @(posedge clk) begin
        if (grant_key) begin
            job_data_q <= {96'd0, key_word};
        end else if (grant_rnd) begin
            job_data_q <= rnd_data;
        end
        lanes_q <= lanes_nxt;
    end

endmodule

// File: tb/tb_aes_sbox_share_ctrl.sv
// Directed bench for aes_sbox_share_ctrl with a behavioural S-box of latency SBOX_LAT.
module tb_aes_sbox_share_ctrl;

    parameter int SBOX_LAT = 1;

    logic         clk;
    logic         rst_n;
    logic         rnd_req;
    logic         rnd_inv;
    logic [127:0] rnd_data;
    logic         rnd_ack;
    logic         rnd_done;
    logic [127:0] rnd_result;
    logic         key_req;
    logic [31:0]  key_word;
    logic         key_ack;
    logic         key_done;
    logic [31:0]  key_result;
    logic [7:0]   sbox_in;
    logic         sbox_inv;
    logic [7:0]   sbox_out;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    aes_sbox_share_ctrl #(.SBOX_LAT(SBOX_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rnd_req    (rnd_req),
        .rnd_inv    (rnd_inv),
        .rnd_data   (rnd_data),
        .rnd_ack    (rnd_ack),
        .rnd_done   (rnd_done),
        .rnd_result (rnd_result),
        .key_req    (key_req),
        .key_word   (key_word),
        .key_ack    (key_ack),
        .key_done   (key_done),
        .key_result (key_result),
        .sbox_in    (sbox_in),
        .sbox_inv   (sbox_inv),
        .sbox_out   (sbox_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference S-box built from GF(2^8) arithmetic
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        if (a == 8'h00) return 8'h00;
        for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] sb_fwd(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sb_inv(input logic [7:0] a);
        return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] sub_state(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sb_fwd(d[8*i +: 8]);
        return r;
    endfunction

    logic [7:0] sbox_f;
    logic [7:0] sbox_pipe [0:3];

    always_comb sbox_f = sbox_inv ? sb_inv(sbox_in) : sb_fwd(sbox_in);

    always @(posedge clk) begin
        sbox_pipe[0] <= sbox_f;
        for (int k = 1; k < 4; k++) sbox_pipe[k] <= sbox_pipe[k-1];
    end

    assign sbox_out = (SBOX_LAT == 0) ? sbox_f : sbox_pipe[(SBOX_LAT == 0) ? 0 : SBOX_LAT - 1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rnd_req = 1'b0; key_req = 1'b0; rnd_inv = 1'b0;
        rnd_data = '0; key_word = '0;
        step(); step();
        n_checks++;
        if ({rnd_ack, rnd_done, key_ack, key_done, busy, sbox_inv} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, need 000000", {rnd_ack, rnd_done, key_ack, key_done, busy, sbox_inv});
        end
        n_checks++;
        if (rnd_result !== '0 || key_result !== '0 || sbox_in !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: rnd_result %h key_result %h sbox_in %h, need all zero", rnd_result, key_result, sbox_in);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy: got %b, need 0", busy);
        end
    endtask

    // Acceptance is expected at the next edge; checks one full key job
    task automatic key_body(input logic [31:0] w, input logic [31:0] exp, input string nm);
        step();
        n_checks++;
        if (key_ack !== 1'b1 || rnd_ack !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ack: key_ack %b rnd_ack %b busy %b, need 1 0 1", nm, key_ack, rnd_ack, busy);
        end
        key_req = 1'b0;
        for (int c = 0; c <= 4 + SBOX_LAT; c++) begin
            if (c > 0) step();
            n_checks++;
            if (busy !== 1'b1 || key_ack !== (c == 0) || key_done !== (c == 4 + SBOX_LAT)) begin
                n_fail++;
                $display("FAIL %s_cyc%0d: busy %b ack %b done %b", nm, c, busy, key_ack, key_done);
            end
            if (c < 4) begin
                n_checks++;
                if (sbox_in !== w[8*c +: 8] || sbox_inv !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_byte%0d: sbox_in %h inv %b, need %h 0", nm, c, sbox_in, sbox_inv, w[8*c +: 8]);
                end
            end
        end
        n_checks++;
        if (key_result !== exp) begin
            n_fail++;
            $display("FAIL %s_result: got %h, need %h", nm, key_result, exp);
        end
    endtask

    task automatic round_body(input logic [127:0] d, input logic inv, input logic [127:0] exp, input string nm);
        step();
        n_checks++;
        if (rnd_ack !== 1'b1 || key_ack !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ack: rnd_ack %b key_ack %b busy %b, need 1 0 1", nm, rnd_ack, key_ack, busy);
        end
        rnd_req = 1'b0;
        for (int c = 0; c <= 16 + SBOX_LAT; c++) begin
            if (c > 0) step();
            n_checks++;
            if (busy !== 1'b1 || rnd_ack !== (c == 0) || rnd_done !== (c == 16 + SBOX_LAT)) begin
                n_fail++;
                $display("FAIL %s_cyc%0d: busy %b ack %b done %b", nm, c, busy, rnd_ack, rnd_done);
            end
            if (c < 16) begin
                n_checks++;
                if (sbox_in !== d[8*c +: 8] || sbox_inv !== inv) begin
                    n_fail++;
                    $display("FAIL %s_byte%0d: sbox_in %h inv %b, need %h %b", nm, c, sbox_in, sbox_inv, d[8*c +: 8], inv);
                end
            end
        end
        n_checks++;
        if (rnd_result !== exp) begin
            n_fail++;
            $display("FAIL %s_result: got %h, need %h", nm, rnd_result, exp);
        end
    endtask

    task automatic test_key_single();
        key_word = 32'h0000_5300;
        key_req  = 1'b1;
        key_body(32'h0000_5300, 32'h6363_ED63, "key_single");
        step();
        n_checks++;
        if (busy !== 1'b0 || key_done !== 1'b0) begin
            n_fail++;
            $display("FAIL key_single_idle: busy %b done %b, need 0 0", busy, key_done);
        end
    endtask

    task automatic test_round_single();
        rnd_data = {16{8'h63}}; rnd_inv = 1'b1; rnd_req = 1'b1;
        round_body({16{8'h63}}, 1'b1, {16{8'h00}}, "rnd_inv");
        step();
        rnd_data = {16{8'h00}}; rnd_inv = 1'b0; rnd_req = 1'b1;
        round_body({16{8'h00}}, 1'b0, {16{8'h63}}, "rnd_fwd");
        step();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_idle: busy %b, need 0", busy);
        end
    endtask

    task automatic test_arbitration();
        logic [127:0] d;
        d = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        rnd_data = d; rnd_inv = 1'b0; rnd_req = 1'b1;
        key_word = 32'h0001_0203; key_req = 1'b1;
        key_body(32'h0001_0203, 32'h637C_777B, "arb_key");
        round_body(d, 1'b0, sub_state(d), "arb_rnd");
        step();
    endtask

    task automatic test_starve();
        logic exp_rnd [6];
        int   last_cyc;
        int   prev_n;
        int   cyc;
        logic found;
`ifdef AES_SBOX_STARVE_GUARD_EN
        exp_rnd = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`else
        exp_rnd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        rnd_data = 128'h00112233_44556677_8899AABB_CCDDEEFF; rnd_inv = 1'b0;
        key_word = 32'hDEAD_BEEF;
        key_req = 1'b1; rnd_req = 1'b1;
        cyc = 0; last_cyc = 0; prev_n = 4;
        for (int g = 0; g < 6; g++) begin
            found = 1'b0;
            for (int t = 0; t < 40 && !found; t++) begin
                step();
                cyc++;
                if (key_ack || rnd_ack) found = 1'b1;
            end
            n_checks++;
            if (!found) begin
                n_fail++;
                $display("FAIL starve_grant%0d: no ack within 40 cycles", g);
            end else begin
                if (rnd_ack !== exp_rnd[g] || key_ack !== !exp_rnd[g]) begin
                    n_fail++;
                    $display("FAIL starve_grant%0d: rnd_ack %b key_ack %b, need rnd %b", g, rnd_ack, key_ack, exp_rnd[g]);
                end
                if (g > 0) begin
                    n_checks++;
                    if (cyc - last_cyc !== prev_n + SBOX_LAT + 1) begin
                        n_fail++;
                        $display("FAIL starve_gap%0d: got %0d cycles, need %0d", g, cyc - last_cyc, prev_n + SBOX_LAT + 1);
                    end
                end
                prev_n   = rnd_ack ? 16 : 4;
                last_cyc = cyc;
            end
        end
        key_req = 1'b0; rnd_req = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            step();
            if (!busy) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL starve_drain: busy still %b after 40 cycles, need 0", busy);
        end
    endtask

    task automatic test_reset_abort();
        logic [127:0] d2;
        rnd_data = 128'hFFEEDDCC_BBAA9988_77665544_33221100; rnd_inv = 1'b0; rnd_req = 1'b1;
        step();
        n_checks++;
        if (rnd_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_ack: got %b, need 1", rnd_ack);
        end
        rnd_req = 1'b0;
        repeat (7) step();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rnd_ack, rnd_done, key_ack, key_done, busy, sbox_inv} !== 6'b0 || sbox_in !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_async_ctrl: flags %b sbox_in %h, need 0", {rnd_ack, rnd_done, key_ack, key_done, busy, sbox_inv}, sbox_in);
        end
        n_checks++;
        if (rnd_result !== '0 || key_result !== '0) begin
            n_fail++;
            $display("FAIL abort_async_result: rnd %h key %h, need zero", rnd_result, key_result);
        end
        for (int t = 0; t < 3; t++) begin
            step();
            n_checks++;
            if (rnd_done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_hold%0d: done %b busy %b, need 0 0", t, rnd_done, busy);
            end
        end
        d2 = 128'h53535353_00010203_CAFEBABE_12345678;
        rnd_data = d2; rnd_inv = 1'b0; rnd_req = 1'b1;
        rst_n = 1'b1;
        round_body(d2, 1'b0, sub_state(d2), "abort_fresh");
        step();
    endtask

    initial begin
        test_reset();
        test_key_single();
        test_round_single();
        test_arbitration();
        test_starve();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
